// File: rtl/lc3_mem_pkg.sv
// Shared types for the LC3 memory-access sequencer: command and state encodings,
// plus the default timeout budget.
package lc3_mem_pkg;

    typedef enum logic [1:0] {
        MOP_LD  = 2'd0,
        MOP_ST  = 2'd1,
        MOP_LDI = 2'd2,
        MOP_STI = 2'd3
    } mem_op_t;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_PTR  = 2'd1,
        MS_ACC  = 2'd2,
        MS_FIN  = 2'd3
    } mem_state_t;

    localparam int MAX_WAIT_DEF = 15;

    function automatic logic op_is_store(input mem_op_t o);
        return (o == MOP_ST) || (o == MOP_STI);
    endfunction

    function automatic logic op_is_indirect(input mem_op_t o);
        return (o == MOP_LDI) || (o == MOP_STI);
    endfunction

endpackage

// File: rtl/lc3_wait_timer.sv
// Counts consecutive un-acked request cycles; expired fires in the cycle whose
// missing ack would make the count reach MAX_WAIT.
module lc3_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + CW'(1);
    end

    // Fires combinationally so the FSM leaves on the same edge the count would hit MAX_WAIT.
    assign expired = inc && (cnt == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/lc3_mem_seq.sv
// LC3 load/store sequencer over a req/ack memory port with indirect pointer phase
// and timeout abort. Define LC3_MEM_STATS_EN to add transfer/abort counters.
module lc3_mem_seq
    import lc3_mem_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata_out,
    output logic              flag_we,
    output logic              n_flag,
    output logic              z_flag,
    output logic              p_flag,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
`ifdef LC3_MEM_STATS_EN
    ,
    output logic [31:0]       acc_count,
    output logic [15:0]       timeout_count
`endif
);

    mem_state_t        state_q, state_d;
    mem_op_t           op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;
    logic              expired;
    logic              xfer;

    lc3_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (!mem_req || mem_ack),
        .inc     (mem_req && !mem_ack),
        .expired (expired)
    );

    assign xfer = mem_req && mem_ack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= MS_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        flag_we = 1'b0;
        case (state_q)
            MS_IDLE: begin
                if (start)
                    state_d = op_is_indirect(mem_op_t'(op)) ? MS_PTR : MS_ACC;
            end
            MS_PTR: begin
                mem_req = 1'b1;
                if (mem_ack)
                    state_d = MS_ACC;
                else if (expired)
                    state_d = MS_FIN;
            end
            MS_ACC: begin
                mem_req = 1'b1;
                mem_we  = op_is_store(op_q);
                if (mem_ack || expired)
                    state_d = MS_FIN;
            end
            MS_FIN: begin
                done    = 1'b1;
                err     = err_q;
                flag_we = !err_q && !op_is_store(op_q);
                state_d = MS_IDLE;
            end
            default: state_d = MS_IDLE;
        endcase
    end

    assign busy      = (state_q != MS_IDLE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // Flags are written alongside rdata_out so they already show the new word while flag_we is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q      <= MOP_LD;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            rdata_out <= '0;
            n_flag    <= 1'b0;
            z_flag    <= 1'b1;
            p_flag    <= 1'b0;
        end else begin
            if (state_q == MS_IDLE && start) begin
                op_q    <= mem_op_t'(op);
                addr_q  <= addr_in;
                wdata_q <= wdata_in;
            end
            if (mem_req)
                err_q <= expired;
            if (state_q == MS_PTR && mem_ack)
                addr_q <= ADDR_W'(mem_rdata);
            if (state_q == MS_ACC && mem_ack && !op_is_store(op_q)) begin
                rdata_out <= mem_rdata;
                n_flag    <= mem_rdata[DATA_W-1];
                z_flag    <= (mem_rdata == '0);
                p_flag    <= !mem_rdata[DATA_W-1] && (mem_rdata != '0);
            end
        end
    end

`ifdef LC3_MEM_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_count     <= '0;
            timeout_count <= '0;
        end else begin
            if (xfer && acc_count != '1)
                acc_count <= acc_count + 32'd1;
            if (mem_req && expired && timeout_count != '1)
                timeout_count <= timeout_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lc3_mem_seq.sv
// Directed + random bench for lc3_mem_seq against a transaction-level model of
// latency, memory effects, load result and NZP flags.
module tb_lc3_mem_seq;

    localparam int MAXW = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [15:0] addr_in, wdata_in;
    logic        busy, done, err, flag_we, n_flag, z_flag, p_flag;
    logic [15:0] rdata_out;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
`ifdef LC3_MEM_STATS_EN
    logic [31:0] acc_count;
    logic [15:0] timeout_count;
`endif

    lc3_mem_seq #(.DATA_W(16), .ADDR_W(16), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .addr_in(addr_in),
        .wdata_in(wdata_in), .busy(busy), .done(done), .err(err),
        .rdata_out(rdata_out), .flag_we(flag_we), .n_flag(n_flag),
        .z_flag(z_flag), .p_flag(p_flag), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
`ifdef LC3_MEM_STATS_EN
        , .acc_count(acc_count), .timeout_count(timeout_count)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory responder: acks after wait_cfg un-acked request cycles.
    logic [15:0] mem [logic [15:0]];
    int          wait_cfg = 0;
    int          wcnt = 0;
    int          req_cycles = 0;
    bit          we_seen = 0;
    logic [15:0] log_addr[$];
    logic [15:0] log_data[$];
    bit          log_we[$];

    function automatic logic [15:0] rd(input logic [15:0] a);
        return mem.exists(a) ? mem[a] : 16'h0000;
    endfunction

    always @(posedge clk) begin
        if (mem_req) begin
            req_cycles++;
            if (mem_we) we_seen = 1;
        end
        if (mem_req && mem_ack) begin
            log_addr.push_back(mem_addr);
            log_we.push_back(mem_we);
            log_data.push_back(mem_we ? mem_wdata : rd(mem_addr));
            if (mem_we) mem[mem_addr] = mem_wdata;
            wcnt = 0;
        end else if (mem_req) begin
            wcnt++;
        end else begin
            wcnt = 0;
        end
    end

    always @(negedge clk) begin
        mem_ack   = mem_req && (wcnt >= wait_cfg);
        mem_rdata = rd(mem_addr);
    end

    // Architectural model state
    logic [15:0] exp_rdata = 16'h0000;
    logic [2:0]  exp_nzp   = 3'b010;

    task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] wd,
                          input int waits, input bit pulse_busy, input string tag);
        bit          ind = o[1];
        bit          st  = o[0];
        bit          tmo = (waits >= MAXW);
        logic [15:0] target = ind ? rd(a) : a;
        logic [15:0] ldval  = rd(target);
        int          phases = ind ? 2 : 1;
        int          exp_lat = tmo ? MAXW + 1 : 1 + phases * (waits + 1);
        int          exp_req = tmo ? MAXW : phases * (waits + 1);
        int          lat = 0, ndone = 0, log0;
        logic        got_err = 0, got_fwe = 0, post_busy = 1;
        logic [15:0] post_rd = 'x;
        logic [2:0]  post_nzp = 'x;

        wait_cfg = waits;
        log0 = log_addr.size();
        req_cycles = 0;
        we_seen = 0;
        start = 1; op = o; addr_in = a; wdata_in = wd;
        for (int c = 1; c <= 120; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = pulse_busy;
                op = 2'd0;
                addr_in = 16'hDEAD;
            end else begin
                start = 0;
            end
            if (done) begin
                ndone++;
                if (lat == 0) begin
                    lat = c; got_err = err; got_fwe = flag_we;
                end
            end
            if (lat != 0 && c == lat + 1) begin
                post_rd = rdata_out; post_nzp = {n_flag, z_flag, p_flag}; post_busy = busy;
            end
            if (lat != 0 && c >= lat + 3) break;
        end

        if (!tmo && !st) begin
            exp_rdata = ldval;
            exp_nzp = ldval[15] ? 3'b100 : (ldval == 0) ? 3'b010 : 3'b001;
        end

        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " done count"}, ndone, 1);
        chk({tag, " err"}, got_err, tmo);
        chk({tag, " flag_we"}, got_fwe, !tmo && !st);
        chk({tag, " req cycles"}, req_cycles, exp_req);
        chk({tag, " rdata_out"}, post_rd, exp_rdata);
        chk({tag, " nzp"}, post_nzp, exp_nzp);
        chk({tag, " busy after"}, post_busy, 0);
        if (!st || tmo) chk({tag, " no write"}, we_seen, 0);
        if (!tmo) begin
            chk({tag, " transfers"}, log_addr.size() - log0, phases);
            if (ind) chk({tag, " ptr addr"}, log_addr[log0], a);
            chk({tag, " data addr"}, log_addr[log_addr.size()-1], target);
            chk({tag, " data we"}, log_we[log_we.size()-1], st);
            if (st) chk({tag, " wdata"}, rd(target), wd);
        end
    endtask

    initial begin
        reset = 0; start = 0; op = 0; addr_in = 0; wdata_in = 0;
        mem_ack = 0; mem_rdata = 0;
        repeat (3) @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        chk("rst rdata", rdata_out, 16'h0000);
        chk("rst nzp", {n_flag, z_flag, p_flag}, 3'b010);
        chk("rst flag_we", flag_we, 0);
        chk("rst mem_req", mem_req, 0);
        reset = 1;
        @(negedge clk);

        mem[16'h3000] = 16'h8001;
        run_op(2'd0, 16'h3000, 16'h0000, 0, 0, "LD0");
        mem[16'h4000] = 16'h4100;
        run_op(2'd3, 16'h4000, 16'h00AA, 3, 0, "STI3");
        mem[16'h5000] = 16'h5005;
        mem[16'h5005] = 16'h0000;
        run_op(2'd2, 16'h5000, 16'h0000, 0, 0, "LDIz");
        mem[16'h6000] = 16'h1234;
        run_op(2'd0, 16'h6000, 16'h0000, 255, 0, "TMO");
        run_op(2'd0, 16'h6000, 16'h0000, MAXW - 1, 1, "ACK15");
        run_op(2'd0, 16'h3000, 16'h0000, 0, 1, "BUSYST");

        // Reset during the write phase of a store
        begin
            int log0;
            mem[16'h7000] = 16'h1111;
            wait_cfg = 10;
            log0 = log_addr.size();
            start = 1; op = 2'd1; addr_in = 16'h7000; wdata_in = 16'hBEEF;
            @(negedge clk); start = 0;
            @(negedge clk);
            chk("mid-ST mem_req", mem_req, 1);
            #2 reset = 0;
            #1;
            chk("rst-mid mem_req", mem_req, 0);
            chk("rst-mid busy", busy, 0);
            repeat (2) @(negedge clk);
            chk("rst-mid no write", rd(16'h7000), 16'h1111);
            chk("rst-mid log", log_addr.size() - log0, 0);
            chk("rst-mid rdata", rdata_out, 16'h0000);
            chk("rst-mid nzp", {n_flag, z_flag, p_flag}, 3'b010);
            exp_rdata = 16'h0000;
            exp_nzp = 3'b010;
            reset = 1;
            @(negedge clk);
        end
        mem[16'h7100] = 16'h0042;
        run_op(2'd0, 16'h7100, 16'h0000, 1, 0, "LDpost");

        for (int i = 0; i < 24; i++) begin
            logic [1:0]  ro = 2'($urandom_range(0, 3));
            logic [15:0] ra = 16'($urandom);
            int          sel = $urandom_range(0, 9);
            int          rw = (sel == 9) ? 255 : (sel == 8) ? MAXW - 1 : $urandom_range(0, 3);
            if (!mem.exists(ra)) mem[ra] = 16'($urandom);
            if (ro[1] && !mem.exists(rd(ra))) mem[rd(ra)] = 16'($urandom_range(0, 2) == 0 ? 0 : $urandom);
            run_op(ro, ra, 16'($urandom), rw, $urandom_range(0, 1), $sformatf("RND%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
